// File: rtl/data_mem_dp_if.sv
// rtl/data_mem_dp_if.sv - request/response bundle for the dual-port data memory
interface data_mem_dp_if #(
  parameter int MEMORY_ADDR_SIZE = 10,
  parameter int MEMORY_DATA_SIZE = 16
);
  logic                          ready;
  logic                          writeEn;
  logic                          readEnA;
  logic [MEMORY_ADDR_SIZE-1:0]   addressA;
  logic [MEMORY_DATA_SIZE-1:0]   dataIn;
  logic [MEMORY_DATA_SIZE/8-1:0] byteEn;
  logic [MEMORY_DATA_SIZE-1:0]   dataOutA;
  logic                          validA;
  logic                          readEnB;
  logic [MEMORY_ADDR_SIZE-1:0]   addressB;
  logic [MEMORY_DATA_SIZE-1:0]   dataOutB;
  logic                          validB;
  logic                          addrErr;

  modport master (
    output writeEn, readEnA, addressA, dataIn, byteEn, readEnB, addressB,
    input  ready, dataOutA, validA, dataOutB, validB, addrErr
  );

  modport slave (
    input  writeEn, readEnA, addressA, dataIn, byteEn, readEnB, addressB,
    output ready, dataOutA, validA, dataOutB, validB, addrErr
  );
endinterface

// File: rtl/data_mem_dp.sv
// rtl/data_mem_dp.sv - dual-port data memory with byte lanes, read pipeline and zero-fill sequencer
module data_mem_dp #(
  parameter int MEMORY_SIZE      = 1024,
  parameter int MEMORY_ADDR_SIZE = 10,
  parameter int MEMORY_DATA_SIZE = 16,
  parameter int READ_LATENCY     = 1
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_dp_if.slave bus
);
  localparam int LANES = MEMORY_DATA_SIZE / 8;
  localparam int IDX_W = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam logic [MEMORY_ADDR_SIZE:0] SIZE_X   = (MEMORY_ADDR_SIZE+1)'(MEMORY_SIZE);
  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(MEMORY_SIZE - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                      state;
  logic [IDX_W-1:0]            clr_cnt;
  logic                        ready_q;
  logic [MEMORY_DATA_SIZE-1:0] mem [MEMORY_SIZE];

  logic                        run, in_a, in_b, wr_ok, rd_a, rd_b, err_a, err_b;
  logic [IDX_W-1:0]            idx_a, idx_b;
  logic [MEMORY_DATA_SIZE-1:0] wr_word, rdata_a, rdata_b;

  logic                        s1_va, s1_vb, s1_err;
  logic [MEMORY_DATA_SIZE-1:0] s1_da, s1_db;

  assign run   = (state == RUN);
  assign in_a  = ({1'b0, bus.addressA} < SIZE_X);
  assign in_b  = ({1'b0, bus.addressB} < SIZE_X);
  assign idx_a = bus.addressA[IDX_W-1:0];
  assign idx_b = bus.addressB[IDX_W-1:0];

  // A write on port A shadows a same-cycle read on port A
  assign wr_ok = run && bus.writeEn && in_a;
  assign rd_a  = run && bus.readEnA && !bus.writeEn;
  assign rd_b  = run && bus.readEnB;
  assign err_a = run && (bus.writeEn || bus.readEnA) && !in_a;
  assign err_b = rd_b && !in_b;

  always_comb begin
    wr_word = mem[idx_a];
    for (int i = 0; i < LANES; i++) begin
      if (bus.byteEn[i]) wr_word[8*i +: 8] = bus.dataIn[8*i +: 8];
    end
  end

  assign rdata_a = in_a ? mem[idx_a] : '0;
  // Write-first bypass so port B sees the merged word on a same-address collision
  assign rdata_b = !in_b ? '0 :
                   (wr_ok && (bus.addressA == bus.addressB)) ? wr_word : mem[idx_b];

  always_ff @(posedge clk) begin
    if (!run) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      mem[idx_a] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready_q <= 1'b0;
      s1_va   <= 1'b0;
      s1_vb   <= 1'b0;
      s1_err  <= 1'b0;
      s1_da   <= '0;
      s1_db   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST_IDX) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        RUN: state <= RUN;
        default: state <= CLEAR;
      endcase
      s1_va  <= rd_a;
      s1_vb  <= rd_b;
      s1_err <= err_a || err_b;
      if (rd_a) s1_da <= rdata_a;
      if (rd_b) s1_db <= rdata_b;
    end
  end

  assign bus.ready = ready_q;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                        s2_va, s2_vb, s2_err;
      logic [MEMORY_DATA_SIZE-1:0] s2_da, s2_db;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s2_va  <= 1'b0;
          s2_vb  <= 1'b0;
          s2_err <= 1'b0;
          s2_da  <= '0;
          s2_db  <= '0;
        end else begin
          s2_va  <= s1_va;
          s2_vb  <= s1_vb;
          s2_err <= s1_err;
          if (s1_va) s2_da <= s1_da;
          if (s1_vb) s2_db <= s1_db;
        end
      end

      assign bus.validA   = s2_va;
      assign bus.validB   = s2_vb;
      assign bus.addrErr  = s2_err;
      assign bus.dataOutA = s2_da;
      assign bus.dataOutB = s2_db;
    end else begin : g_lat1
      assign bus.validA   = s1_va;
      assign bus.validB   = s1_vb;
      assign bus.addrErr  = s1_err;
      assign bus.dataOutA = s1_da;
      assign bus.dataOutB = s1_db;
    end
  endgenerate
endmodule
